cgra_ram_stream_reader: RTL and testbench
=========================================

Name: cgra_ram_stream_reader

Overview:
- Downstream consumer of the CGRA subsystem's single-port-read word RAM.
- Reads a contiguous address window and presents the words as a valid/ready stream, e.g. config-bitstream words fed to the CGRA fabric.
- Hides the RAM's 1-cycle registered read latency behind a small credit-controlled FIFO.
- Sustains one word per cycle under no backpressure.

Parameters:
- WIDTH, 32, data word width; matches the RAM WIDTH.
- DEPTH, 512, RAM word count; addresses wrap modulo DEPTH.
- ADDR_WIDTH, $clog2(DEPTH), RAM address width.
- LEN_WIDTH, ADDR_WIDTH+1, width of the transfer length field, so a full-RAM transfer is expressible.
- FIFO_DEPTH, 4, output buffer entries; minimum 2.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first word address, captured on start.
- length  in  LEN_WIDTH  word count, captured on start; 0 is legal.
- busy  out  1  high while in RUN or DRAIN.
- done  out  1  one-cycle pulse at completion.
- ram_rd_en  out  1  RAM read enable.
- ram_rd_addr  out  ADDR_WIDTH  RAM read address.
- ram_rd_data  in  WIDTH  RAM read data; valid the cycle after ram_rd_en.
- out_valid  out  1  stream valid.
- out_data  out  WIDTH  stream data.
- out_last  out  1  high with the final word of a transfer.
- out_ready  in  1  stream ready.

Behaviour:
- Reset values, asynchronous on rst_n=0: state=IDLE; busy, done, ram_rd_en, out_valid and out_last =0; ram_rd_addr, out_data =0; FIFO emptied; in-flight flag and counters cleared. Reset mid-transfer aborts it with no done pulse, and any RAM data returning after reset is discarded.
- IDLE state:
  - start=1 captures base_addr into rd_ptr, and length into issue_cnt and out_cnt.
  - If length=0: go to IDLE, pulse done the next cycle, no RAM access.
  - Otherwise go to RUN.
  - start while busy is ignored.
- RUN state (issuing reads):
  - Assert ram_rd_en with ram_rd_addr=rd_ptr when issue_cnt>0 and fifo_count+inflight < FIFO_DEPTH. inflight is a 1-bit register set on issue and cleared the next cycle.
  - On issue: rd_ptr increments, wrapping from DEPTH-1 to 0, and issue_cnt decrements.
  - When issue_cnt reaches 0, go to DRAIN.
- Capture: in the cycle after an issue, ram_rd_data is pushed into the FIFO. The credit rule guarantees the FIFO never overflows.
- Output stream:
  - out_valid = FIFO non-empty; out_data = FIFO head.
  - A handshake is out_valid & out_ready: pop the head and decrement out_cnt.
  - out_last = out_valid & (out_cnt==1).
  - out_data and out_last hold stable while out_valid=1 and out_ready=0.
  - Push and pop in the same cycle leave fifo_count unchanged.
- DRAIN state: on the handshake with out_cnt==1, pulse done in the next cycle and go to IDLE. busy falls in that same cycle.
- Latency:
  - start sampled at edge E0.
  - First ram_rd_en in the cycle after E0.
  - First out_valid two cycles after E0.
  - With out_ready held 1: one word per cycle; done pulse L+2 cycles after E0 for length L.
- Wrap: base_addr=DEPTH-2 with length=4 reads DEPTH-2, DEPTH-1, 0, 1 in order.
- Full-RAM transfer: length=DEPTH is legal.
- Length greater than DEPTH: addresses keep wrapping; no error is flagged.

Optional Feature:
- Macro CGRA_STREAM_CHECKSUM_EN.
- With the macro defined:
  - Adds output checksum [WIDTH].
  - checksum is the XOR of all words handshaked in the current transfer.
  - It clears to 0 on an accepted start and on reset.
  - It is stable and valid in the done-pulse cycle and holds until the next accepted start.
- Without the macro: no checksum port or logic.

Test Plan:
- RAM[i]=i+0x100, start base=0 length=8, out_ready=1 -> words 0x100..0x107 on consecutive cycles; out_last on 0x107; done one cycle later; busy low afterwards.
- base=510, length=4 (DEPTH=512) -> ram_rd_addr sequence 510, 511, 0, 1; out_data follows the same order.
- length=8, out_ready toggling 1,0,0,1 repeating -> no word lost or duplicated; out_data stable while stalled; ram_rd_en never issued when fifo_count+inflight=4.
- length=0 -> no ram_rd_en and no out_valid; done pulses once, the cycle after start.
- rst_n low for 1 cycle after the 3rd word of a 16-word transfer -> all outputs 0 immediately and no done; a new start base=0 length=2 then completes normally.
- CGRA_STREAM_CHECKSUM_EN, words 0xA5A5_0000, 0x0000_5A5A, 0xFFFF_FFFF -> checksum=0x5A5A_A5A5 in the done cycle.

Source files
------------

// File: rtl/cgra_ram_stream_reader.sv
// cgra_ram_stream_reader
//
// Streams a contiguous window of the CGRA subsystem's word RAM out as a
// valid/ready stream (e.g. config-bitstream words for the fabric). The RAM
// has a one-cycle registered read latency. That latency is hidden behind a
// small output FIFO. Reads are only issued when a FIFO slot is guaranteed
// for the returning word, so the FIFO can never overflow. With no
// backpressure the block sustains one word per cycle.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   start                one-cycle request, sampled only while idle
//   base_addr, length    first word address and word count, captured on start
//   busy                 high while a transfer is issuing or draining
//   done                 one-cycle pulse after the final word is accepted
//   ram_rd_en            RAM read enable
//   ram_rd_addr          RAM read address
//   ram_rd_data          RAM read data, valid the cycle after ram_rd_en
//   out_valid, out_data  output stream
//   out_last             marks the final word of a transfer
//   out_ready            output stream backpressure
//   checksum             XOR of the words accepted in the current transfer
//                        (only when CGRA_STREAM_CHECKSUM_EN is defined)
//
// Optional feature macro: CGRA_STREAM_CHECKSUM_EN

module cgra_ram_stream_reader #(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 512,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int LEN_WIDTH  = ADDR_WIDTH + 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0]  length,
   output logic                  busy,
   output logic                  done,
   output logic                  ram_rd_en,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [WIDTH-1:0]      ram_rd_data,
   output logic                  out_valid,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_last,
   input  logic                  out_ready
`ifdef CGRA_STREAM_CHECKSUM_EN
   ,
   output logic [WIDTH-1:0]      checksum
`endif
);

   localparam int FIFO_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [LEN_WIDTH-1:0]  issue_cnt;
   logic [LEN_WIDTH-1:0]  out_cnt;
   logic                  inflight;

   logic [WIDTH-1:0]      fifo_mem [FIFO_DEPTH];
   logic [FIFO_AW-1:0]    wr_idx;
   logic [FIFO_AW-1:0]    rd_idx;
   logic [CNT_W-1:0]      fifo_count;
   logic [CNT_W-1:0]      count_next;
   logic [CNT_W:0]        credit_sum;
   logic                  push;
   logic                  pop;
   logic                  can_issue;

   function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
      return (a == ADDR_WIDTH'(DEPTH - 1)) ? '0 : a + 1'b1;
   endfunction

   function automatic logic [FIFO_AW-1:0] idx_inc(input logic [FIFO_AW-1:0] i);
      return (i == FIFO_AW'(FIFO_DEPTH - 1)) ? '0 : i + 1'b1;
   endfunction

   // The stream side is driven straight from the FIFO registers: valid while
   // anything is buffered, data is the head entry, and last is flagged when
   // the head is the final word still owed to the consumer.
   assign out_valid = (fifo_count != '0);
   assign out_data  = fifo_mem[rd_idx];
   assign out_last  = out_valid & (out_cnt == LEN_WIDTH'(1));

   // Credit check for the read issued in the next cycle. The word returning
   // this cycle (inflight) lands in the FIFO at this edge, and any pop leaves
   // it. The read being issued right now still needs a slot later. A new read
   // is allowed only if, after all of that, one more slot remains free.
   always_comb begin
      push       = inflight;
      pop        = out_valid & out_ready;
      count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
      credit_sum = {1'b0, count_next} + {{CNT_W{1'b0}}, ram_rd_en};
      can_issue  = (issue_cnt != '0) && (credit_sum < (CNT_W + 1)'(FIFO_DEPTH));
   end

   // Output FIFO: captures RAM data one cycle after each read and hands words
   // to the stream. Entries are cleared on reset so out_data reads zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem[i] <= '0;
         end
         wr_idx     <= '0;
         rd_idx     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            fifo_mem[wr_idx] <= ram_rd_data;
            wr_idx           <= idx_inc(wr_idx);
         end
         if (pop) begin
            rd_idx <= idx_inc(rd_idx);
         end
         fifo_count <= count_next;
      end
   end

   // Transfer control. The first read is issued straight from IDLE, so the
   // RAM is addressed in the cycle right after start. Reads then continue in
   // RUN while credit allows. DRAIN waits for the consumer to take the last
   // word. inflight follows ram_rd_en by one cycle to mark the returning
   // word. Because reset clears it, data from a read in progress at reset is
   // never captured.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rd_ptr      <= '0;
         issue_cnt   <= '0;
         out_cnt     <= '0;
         inflight    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         ram_rd_en   <= 1'b0;
         ram_rd_addr <= '0;
      end else begin
         done     <= 1'b0;
         inflight <= ram_rd_en;
         if (pop) begin
            out_cnt <= out_cnt - 1'b1;
         end
         case (state)
            IDLE: begin
               ram_rd_en <= 1'b0;
               if (start) begin
                  out_cnt <= length;
                  if (length == '0) begin
                     done      <= 1'b1;
                     rd_ptr    <= base_addr;
                     issue_cnt <= '0;
                  end else begin
                     busy        <= 1'b1;
                     ram_rd_en   <= 1'b1;
                     ram_rd_addr <= base_addr;
                     rd_ptr      <= addr_inc(base_addr);
                     issue_cnt   <= length - 1'b1;
                     state       <= (length == LEN_WIDTH'(1)) ? DRAIN : RUN;
                  end
               end
            end
            RUN: begin
               if (can_issue) begin
                  ram_rd_en   <= 1'b1;
                  ram_rd_addr <= rd_ptr;
                  rd_ptr      <= addr_inc(rd_ptr);
                  issue_cnt   <= issue_cnt - 1'b1;
                  if (issue_cnt == LEN_WIDTH'(1)) begin
                     state <= DRAIN;
                  end
               end else begin
                  ram_rd_en <= 1'b0;
               end
            end
            DRAIN: begin
               ram_rd_en <= 1'b0;
               if (pop && (out_cnt == LEN_WIDTH'(1))) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               ram_rd_en <= 1'b0;
            end
         endcase
      end
   end

`ifdef CGRA_STREAM_CHECKSUM_EN
   // Running XOR of accepted words. It restarts on every accepted start. It
   // holds after the last handshake, so it is final in the done cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         checksum <= '0;
      end else if ((state == IDLE) && start) begin
         checksum <= '0;
      end else if (pop) begin
         checksum <= checksum ^ out_data;
      end
   end
`endif

endmodule

// File: tb/tb_cgra_ram_stream_reader.sv
// tb_cgra_ram_stream_reader
//
// Scoreboard bench for cgra_ram_stream_reader. Each request pushes the
// expected read addresses and stream words, taken from a behavioural RAM
// array, into queues. A monitor samples on the falling edge and pops/compares
// whenever the DUT reads the RAM or completes a stream handshake. The monitor
// also checks stall stability, the credit bound on outstanding reads, start
// latencies and done timing. Covers CGRA_STREAM_CHECKSUM_EN when defined.

module tb_cgra_ram_stream_reader;

   localparam int WIDTH      = 32;
   localparam int DEPTH      = 512;
   localparam int ADDR_WIDTH = 9;
   localparam int LEN_WIDTH  = 10;
   localparam int FIFO_DEPTH = 4;

   logic                  clk;
   logic                  rst_n;
   logic                  start;
   logic [ADDR_WIDTH-1:0] base_addr;
   logic [LEN_WIDTH-1:0]  length;
   logic                  busy;
   logic                  done;
   logic                  ram_rd_en;
   logic [ADDR_WIDTH-1:0] ram_rd_addr;
   logic [WIDTH-1:0]      ram_rd_data;
   logic                  out_valid;
   logic [WIDTH-1:0]      out_data;
   logic                  out_last;
   logic                  out_ready;
`ifdef CGRA_STREAM_CHECKSUM_EN
   logic [WIDTH-1:0]      checksum;
`endif

   logic [WIDTH-1:0] ram_mem [DEPTH];

   logic [WIDTH-1:0] exp_data_q [$];
   logic             exp_last_q [$];
   int               addr_q [$];

   int total = 0;
   int bad = 0;
   int cycle = 0;
   int done_due = -1;
   int done_seen = 0;
   int done_cycle = -1;
   int start_cycle = -1;
   bit rd_pending = 1'b0;
   bit first_pending = 1'b0;
   int issued_cnt = 0;
   int accepted_cnt = 0;
   int hs_in_xfer = 0;
   int ready_mode = 0;
   logic [WIDTH-1:0] exp_sum = '0;

   cgra_ram_stream_reader #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .LEN_WIDTH(LEN_WIDTH),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .base_addr(base_addr),
      .length(length),
      .busy(busy),
      .done(done),
      .ram_rd_en(ram_rd_en),
      .ram_rd_addr(ram_rd_addr),
      .ram_rd_data(ram_rd_data),
      .out_valid(out_valid),
      .out_data(out_data),
      .out_last(out_last),
      .out_ready(out_ready)
`ifdef CGRA_STREAM_CHECKSUM_EN
      ,
      .checksum(checksum)
`endif
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Counts rising edges so the monitor can timestamp its samples.
   initial begin
      forever begin
         @(posedge clk);
         cycle++;
      end
   end

   // Behavioural RAM with a one-cycle registered read.
   initial begin
      ram_rd_data = '0;
      forever begin
         @(posedge clk);
         if (ram_rd_en) ram_rd_data <= ram_mem[ram_rd_addr];
      end
   end

   // Drives out_ready just after each rising edge: always ready, the
   // 1,0,0,1 pattern, or random with roughly 75% ready.
   initial begin
      int phase;
      phase = 0;
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            1: out_ready = ((phase % 4) == 0) || ((phase % 4) == 3);
            2: out_ready = ($urandom % 4) != 0;
            default: out_ready = 1'b1;
         endcase
         phase++;
      end
   end

   // Bounds the whole run in case the DUT hangs.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired actual=running required=finished");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: pops the scoreboard queues when the DUT reads or streams.
   initial begin
      logic             pv;
      logic             pr;
      logic             pl;
      logic [WIDTH-1:0] pd;
      logic [WIDTH-1:0] wd;
      logic             wl;
      pv = 1'b0;
      pr = 1'b0;
      pl = 1'b0;
      pd = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pv = 1'b0;
            continue;
         end
         if (ram_rd_en) begin
            if (rd_pending) begin
               checkOutput("first_rd_latency", 64'(cycle), 64'(start_cycle));
               rd_pending = 1'b0;
            end
            if (addr_q.size() == 0) begin
               checkOutput("unexpected_rd", 1, 0);
            end else begin
               checkOutput("rd_addr", 64'(ram_rd_addr), 64'(addr_q.pop_front()));
            end
            issued_cnt++;
            checkOutput("credit_limit", 64'((issued_cnt - accepted_cnt) <= FIFO_DEPTH), 1);
         end
         if (pv && !pr) begin
            checkOutput("stall_valid", 64'(out_valid), 1);
            checkOutput("stall_data", 64'(out_data), 64'(pd));
            checkOutput("stall_last", 64'(out_last), 64'(pl));
         end
         if (out_valid) begin
            checkOutput("valid_without_word", 64'(exp_data_q.size() == 0), 0);
            if (first_pending) begin
               checkOutput("first_valid_latency", 64'(cycle), 64'(start_cycle + 2));
               first_pending = 1'b0;
            end
         end
         if (out_valid && out_ready && (exp_data_q.size() != 0)) begin
            accepted_cnt++;
            hs_in_xfer++;
            wd = exp_data_q.pop_front();
            wl = exp_last_q.pop_front();
            checkOutput("out_data", 64'(out_data), 64'(wd));
            checkOutput("out_last", 64'(out_last), 64'(wl));
            checkOutput("busy_during", 64'(busy), 1);
            if (wl) done_due = cycle + 1;
         end
         checkOutput("done", 64'(done), 64'(cycle == done_due));
         if (done) begin
            done_seen++;
            done_cycle = cycle;
            checkOutput("busy_after_done", 64'(busy), 0);
`ifdef CGRA_STREAM_CHECKSUM_EN
            checkOutput("checksum_done", 64'(checksum), 64'(exp_sum));
`endif
         end
         pv = out_valid;
         pr = out_ready;
         pd = out_data;
         pl = out_last;
      end
   end

   // Issues one transfer and loads the scoreboard. Called just after a
   // rising edge; optionally waits (bounded) for completion and checks it.
   task automatic applyStimulus(input int base, input int len, input int mode, input bit wait_done);
      int idx;
      int budget;
      ready_mode = mode;
      exp_sum = '0;
      for (int i = 0; i < len; i++) begin
         idx = (base + i) % DEPTH;
         addr_q.push_back(idx);
         exp_data_q.push_back(ram_mem[idx]);
         exp_last_q.push_back(i == len - 1);
         exp_sum = exp_sum ^ ram_mem[idx];
      end
      issued_cnt = 0;
      accepted_cnt = 0;
      hs_in_xfer = 0;
      done_seen = 0;
      start_cycle = cycle + 1;
      rd_pending = (len != 0);
      first_pending = (len != 0);
      if (len == 0) done_due = cycle + 1;
      base_addr = ADDR_WIDTH'(base);
      length = LEN_WIDTH'(len);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (wait_done) begin
         budget = len * 8 + 50;
         for (int n = 0; n < budget && done_seen == 0; n++) begin
            @(posedge clk);
            #1;
         end
         checkOutput("done_timeout", 64'(done_seen != 0), 1);
         repeat (2) begin
            @(posedge clk);
            #1;
         end
         checkOutput("done_once", 64'(done_seen), 1);
         checkOutput("words_left", 64'(exp_data_q.size()), 0);
         checkOutput("reads_left", 64'(addr_q.size()), 0);
         checkOutput("busy_idle", 64'(busy), 0);
         if (mode == 0) begin
            checkOutput("done_latency", 64'(done_cycle), 64'((len == 0) ? start_cycle : start_cycle + len + 2));
         end
      end
   endtask

   initial begin
      int tlen;
      rst_n = 1'b0;
      start = 1'b0;
      base_addr = '0;
      length = '0;
      for (int i = 0; i < DEPTH; i++) ram_mem[i] = WIDTH'(i + 32'h100);

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_busy", 64'(busy), 0);
      checkOutput("reset_done", 64'(done), 0);
      checkOutput("reset_rd_en", 64'(ram_rd_en), 0);
      checkOutput("reset_rd_addr", 64'(ram_rd_addr), 0);
      checkOutput("reset_valid", 64'(out_valid), 0);
      checkOutput("reset_last", 64'(out_last), 0);
      checkOutput("reset_data", 64'(out_data), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] basic 8-word transfer");
      applyStimulus(0, 8, 0, 1);
      $display("[TB] wrap at top of RAM");
      applyStimulus(DEPTH - 2, 4, 0, 1);
      $display("[TB] backpressure 1,0,0,1");
      applyStimulus(37, 8, 1, 1);
      $display("[TB] zero-length transfer");
      applyStimulus(5, 0, 0, 1);

      $display("[TB] reset in the middle of a transfer");
      applyStimulus(100, 16, 0, 0);
      for (int n = 0; n < 100 && hs_in_xfer < 3; n++) begin
         @(posedge clk);
         #1;
      end
      checkOutput("third_word_seen", 64'(hs_in_xfer >= 3), 1);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_busy", 64'(busy), 0);
      checkOutput("abort_done", 64'(done), 0);
      checkOutput("abort_rd_en", 64'(ram_rd_en), 0);
      checkOutput("abort_rd_addr", 64'(ram_rd_addr), 0);
      checkOutput("abort_valid", 64'(out_valid), 0);
      checkOutput("abort_last", 64'(out_last), 0);
      checkOutput("abort_data", 64'(out_data), 0);
      exp_data_q.delete();
      exp_last_q.delete();
      addr_q.delete();
      done_due = -1;
      rd_pending = 1'b0;
      first_pending = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      checkOutput("no_done_after_abort", 64'(done_seen), 0);
      applyStimulus(0, 2, 0, 1);

`ifdef CGRA_STREAM_CHECKSUM_EN
      $display("[TB] checksum vector");
      ram_mem[20] = 32'hA5A5_0000;
      ram_mem[21] = 32'h0000_5A5A;
      ram_mem[22] = 32'hFFFF_FFFF;
      applyStimulus(20, 3, 0, 1);
      checkOutput("checksum_vector", 64'(checksum), 64'h5A5A_A5A5);
`endif

      $display("[TB] randomized transfers");
      for (int i = 0; i < DEPTH; i++) ram_mem[i] = $urandom;
      for (int t = 0; t < 25; t++) begin
         tlen = (($urandom % 6) == 0) ? 0 : int'($urandom_range(1, 40));
         applyStimulus(int'($urandom_range(0, DEPTH - 1)), tlen, int'($urandom_range(0, 2)), 1);
      end
      $display("[TB] full-RAM and oversized transfers");
      applyStimulus(int'($urandom_range(0, DEPTH - 1)), DEPTH, 2, 1);
      applyStimulus(DEPTH - 3, DEPTH + 5, 0, 1);

      $display("[TB] test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
